// File: rtl/led_pattern_seq.sv
// Parametrised LED pattern sequencer: SCAN/SHIFT/BOUNCE/BLINK, tick-enabled, debounced mode button.
// Optional macro LED_DIM_EN adds a 4-bit PWM brightness control on the LED drive.
module led_pattern_seq #(
  parameter int unsigned LED_W   = 16,
  parameter int unsigned DIV_W   = 24,
  parameter int unsigned DEB_CNT = 1000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_dir,
  input  logic             btn_mode,
  input  logic [1:0]       speed,
`ifdef LED_DIM_EN
  input  logic [3:0]       brightness,
`endif
  output logic [LED_W-1:0] led,
  output logic [1:0]       mode
);

  localparam int unsigned POS_W = $clog2(LED_W);
  localparam int unsigned H     = LED_W / 2;
  localparam int unsigned Q     = LED_W / 4;
  localparam int unsigned DEB_W = $clog2(DEB_CNT + 1);
  localparam logic [LED_W-1:0] RST_LED = {2{H'(1) | (H'(1) << (H - 1))}};

  typedef enum logic [1:0] {M_SCAN, M_SHIFT, M_BOUNCE, M_BLINK} mode_t;

  mode_t             r_mode;
  logic [POS_W-1:0]  r_pos;
  logic              r_bdir;
  logic [DIV_W-1:0]  r_div;
  logic [DEB_W-1:0]  r_deb_cnt;
  logic              r_deb_lvl;
  logic              r_dir_s1, r_dir_s2;
  logic              r_mode_s1, r_mode_s2;
  logic [LED_W-1:0]  r_led;

  int unsigned       w_sh;
  logic [DIV_W-1:0]  w_mask;
  logic              w_tick;
  logic              w_deb_diff;
  logic              w_deb_flip;
  logic              w_press;
  logic [POS_W-1:0]  w_pos_nxt;
  logic              w_bdir_nxt;
  logic [H-1:0]      w_half;
  logic [LED_W-1:0]  w_pat;
  logic [LED_W-1:0]  w_led_nxt;

  // Tick when the low (DIV_W-3+speed) prescaler bits are all ones
  always_comb begin
    w_sh   = DIV_W - 3 + 32'(speed);
    w_mask = ~({DIV_W{1'b1}} << w_sh);
    w_tick = ((r_div & w_mask) == w_mask);
  end

  assign w_deb_diff = r_mode_s2 ^ r_deb_lvl;
  assign w_deb_flip = w_deb_diff && (r_deb_cnt == DEB_W'(DEB_CNT - 1));
  assign w_press    = w_deb_flip && !r_deb_lvl;

  // Next position for the current mode and direction
  always_comb begin
    w_pos_nxt  = r_pos;
    w_bdir_nxt = r_bdir;
    case (r_mode)
      M_SCAN: begin
        if (!r_dir_s2) w_pos_nxt = (r_pos == POS_W'(Q - 1)) ? '0 : r_pos + POS_W'(1);
        else           w_pos_nxt = (r_pos == '0) ? POS_W'(Q - 1) : r_pos - POS_W'(1);
      end
      M_SHIFT: begin
        if (!r_dir_s2) w_pos_nxt = (r_pos == POS_W'(LED_W - 1)) ? '0 : r_pos + POS_W'(1);
        else           w_pos_nxt = (r_pos == '0) ? POS_W'(LED_W - 1) : r_pos - POS_W'(1);
      end
      M_BOUNCE: begin
        if (!r_bdir) begin
          if (r_pos == POS_W'(LED_W - 1)) begin
            w_pos_nxt  = r_pos - POS_W'(1);
            w_bdir_nxt = 1'b1;
          end else begin
            w_pos_nxt  = r_pos + POS_W'(1);
          end
        end else begin
          if (r_pos == '0) begin
            w_pos_nxt  = POS_W'(1);
            w_bdir_nxt = 1'b0;
          end else begin
            w_pos_nxt  = r_pos - POS_W'(1);
          end
        end
      end
      default: w_pos_nxt = (r_pos == '0) ? POS_W'(1) : '0;
    endcase
  end

  // Pattern for the current mode/pos
  always_comb begin
    w_half = (H'(1) << r_pos) | (H'(1) << (H - 1 - 32'(r_pos)));
    w_pat  = '0;
    case (r_mode)
      M_SCAN:            w_pat = {w_half, w_half};
      M_SHIFT, M_BOUNCE: w_pat = LED_W'(1) << (LED_W - 1 - 32'(r_pos));
      default:           w_pat = (r_pos == '0) ? '1 : '0;
    endcase
  end

`ifdef LED_DIM_EN
  logic [3:0] r_pwm;
  logic       w_on;
  assign w_on      = (brightness == 4'hF) || (r_pwm < brightness);
  assign w_led_nxt = w_pat & {LED_W{w_on}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pwm <= '0;
    else        r_pwm <= r_pwm + 4'd1;
  end
`else
  assign w_led_nxt = w_pat;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode    <= M_SCAN;
      r_pos     <= '0;
      r_bdir    <= 1'b0;
      r_div     <= '0;
      r_deb_cnt <= '0;
      r_deb_lvl <= 1'b0;
      r_dir_s1  <= 1'b0;
      r_dir_s2  <= 1'b0;
      r_mode_s1 <= 1'b0;
      r_mode_s2 <= 1'b0;
      r_led     <= RST_LED;
    end else begin
      r_dir_s1  <= btn_dir;
      r_dir_s2  <= r_dir_s1;
      r_mode_s1 <= btn_mode;
      r_mode_s2 <= r_mode_s1;
      r_div     <= r_div + DIV_W'(1);
      r_led     <= w_led_nxt;
      if (!w_deb_diff || w_deb_flip) r_deb_cnt <= '0;
      else                            r_deb_cnt <= r_deb_cnt + DEB_W'(1);
      if (w_deb_flip) r_deb_lvl <= ~r_deb_lvl;
      // A mode press overrides a coincident tick
      if (w_press) begin
        r_mode <= mode_t'(2'(r_mode + 2'd1));
        r_pos  <= '0;
        r_bdir <= 1'b0;
      end else if (w_tick) begin
        r_pos  <= w_pos_nxt;
        r_bdir <= w_bdir_nxt;
      end
    end
  end

  assign led  = r_led;
  assign mode = r_mode;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Randomised bench for led_pattern_seq against a cycle-level arithmetic reference model.
module tb_led_pattern_seq;

  localparam int LED_W   = 16;
  localparam int DIV_W   = 4;
  localparam int DEB_CNT = 4;
  localparam int H       = LED_W / 2;
  localparam int Q       = LED_W / 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             btn_dir = 1'b0;
  logic             btn_mode = 1'b0;
  logic [1:0]       speed = 2'd0;
  logic [3:0]       bri = 4'hF;
  logic [LED_W-1:0] led;
  logic [1:0]       mode;

  int n_tests = 0;
  int n_fail  = 0;

  led_pattern_seq #(.LED_W(LED_W), .DIV_W(DIV_W), .DEB_CNT(DEB_CNT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_dir    (btn_dir),
    .btn_mode   (btn_mode),
    .speed      (speed),
`ifdef LED_DIM_EN
    .brightness (bri),
`endif
    .led        (led),
    .mode       (mode)
  );

  always #5 clk = ~clk;

  // Reference model state
  int m_div, m_pwm, m_mode, m_pos, m_ph, m_dcnt;
  bit m_d1, m_d2, m_b1, m_b2, m_lvl;
  logic [LED_W-1:0] m_led;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [LED_W-1:0] pattern(input int md, input int p);
    int h;
    case (md)
      0: begin
        h = (1 << p) | (1 << (H - 1 - p));
        return LED_W'(h) | (LED_W'(h) << H);
      end
      1, 2: return LED_W'(1) << (LED_W - 1 - p);
      default: return (p == 0) ? {LED_W{1'b1}} : {LED_W{1'b0}};
    endcase
  endfunction

  task automatic model_reset();
    m_div = 0; m_pwm = 0; m_mode = 0; m_pos = 0; m_ph = 0; m_dcnt = 0;
    m_d1 = 0; m_d2 = 0; m_b1 = 0; m_b2 = 0; m_lvl = 0;
    m_led = pattern(0, 0);
  endtask

  // One clock edge of the reference model, using the inputs present at that edge
  task automatic model_step();
    int  period;
    bit  tick, press, on;
    logic [LED_W-1:0] nl;
    period = 1 << (DIV_W - 3 + int'(speed));
    tick   = (m_div % period) == period - 1;
    press  = 0;
    if (m_b2 != m_lvl) begin
      if (m_dcnt + 1 == DEB_CNT) begin
        press  = !m_lvl;
        m_lvl  = !m_lvl;
        m_dcnt = 0;
      end else m_dcnt++;
    end else m_dcnt = 0;
`ifdef LED_DIM_EN
    on = (bri == 4'hF) || (m_pwm < int'(bri));
`else
    on = 1;
`endif
    nl = on ? pattern(m_mode, m_pos) : '0;
    if (press) begin
      m_mode = (m_mode + 1) % 4;
      m_pos  = 0;
      m_ph   = 0;
    end else if (tick) begin
      case (m_mode)
        0: m_pos = m_d2 ? (m_pos + Q - 1) % Q : (m_pos + 1) % Q;
        1: m_pos = m_d2 ? (m_pos + LED_W - 1) % LED_W : (m_pos + 1) % LED_W;
        2: begin
          m_ph  = (m_ph + 1) % (2 * (LED_W - 1));
          m_pos = (m_ph < LED_W) ? m_ph : 2 * (LED_W - 1) - m_ph;
        end
        default: m_pos = 1 - m_pos;
      endcase
    end
    m_led = nl;
    m_div = (m_div + 1) % (1 << DIV_W);
    m_pwm = (m_pwm + 1) % 16;
    m_d2 = m_d1; m_d1 = btn_dir;
    m_b2 = m_b1; m_b1 = btn_mode;
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step();
      #1;
      check("led", 32'(led), 32'(m_led));
      check("mode", 32'(mode), 32'(m_mode));
    end
  endtask

  initial begin
    int hold;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_led", 32'(led), 32'h8181);
    check("rst_mode", 32'(mode), 32'd0);
    rst_n = 1'b1;

    // SCAN forward, then reverse
    cyc(12);
    btn_dir = 1'b1;
    cyc(12);
    btn_dir = 1'b0;
    cyc(6);
    // Short glitch on mode button must be ignored, long hold advances to SHIFT
    btn_mode = 1'b1; cyc(2);
    btn_mode = 1'b0; cyc(8);
    check("glitch_mode", 32'(mode), 32'd0);
    btn_mode = 1'b1; cyc(8);
    btn_mode = 1'b0; cyc(40);
    check("shift_mode", 32'(mode), 32'd1);
    // BOUNCE at slowest speed across both ends
    btn_mode = 1'b1; cyc(8);
    btn_mode = 1'b0; speed = 2'd3;
    cyc(560);
    check("bounce_mode", 32'(mode), 32'd2);
`ifdef LED_DIM_EN
    speed = 2'd0;
    btn_mode = 1'b1; cyc(8);
    btn_mode = 1'b0; cyc(8);
    btn_mode = 1'b1; cyc(8);
    btn_mode = 1'b0; bri = 4'd4; cyc(64);
    bri = 4'hF; cyc(32);
`endif
    // BLINK, then asynchronous reset between edges
    speed = 2'd0;
    while (mode != 2'd3) begin
      btn_mode = 1'b1; cyc(8);
      btn_mode = 1'b0; cyc(8);
    end
    cyc(10);
    #2 rst_n = 1'b0;
    #1;
    check("async_led", 32'(led), 32'h8181);
    check("async_mode", 32'(mode), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("hold_led", 32'(led), 32'h8181);
    rst_n = 1'b1;
    model_reset();

    // Randomised traffic
    hold = 0;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 40) == 0) btn_dir = ~btn_dir;
      if ($urandom_range(0, 60) == 0) speed = 2'($urandom_range(0, 3));
`ifdef LED_DIM_EN
      if ($urandom_range(0, 80) == 0) bri = 4'($urandom_range(0, 15));
`endif
      if (hold == 0) begin
        btn_mode = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 12);
      end
      hold--;
      cyc(1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
